// File: rtl/breath_pkg.sv
// Shared state encoding and duty-step constant functions for the breathing-LED path.
package breath_pkg;

    localparam int unsigned LEVEL_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE    = 3'd1,
        HOLD_HI = 3'd2,
        FALL    = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    // Linear duty increment per brightness level; also used by the PWM stage.
    function automatic int unsigned duty_step(input int unsigned pwm_cycle,
                                              input int unsigned level_max);
        return pwm_cycle / level_max;
    endfunction

    // Quadratic (perceptual) duty increment per squared level.
    function automatic int unsigned duty_step2(input int unsigned pwm_cycle,
                                               input int unsigned level_max);
        return pwm_cycle / (level_max * level_max);
    endfunction

endpackage

// File: rtl/breath_duty_map.sv
// Combinational level -> duty mapping. Linear by default; quadratic when
// BREATH_GAMMA_EN is defined.
module breath_duty_map
    import breath_pkg::*;
#(
    parameter int unsigned PWM_CYCLE = 500_000,
    parameter int unsigned DUTY_W    = 19,
    parameter int unsigned LEVEL_MAX = 10
) (
    input  logic [LEVEL_W-1:0] level,
    output logic [DUTY_W-1:0]  duty_c
);

`ifdef BREATH_GAMMA_EN
    localparam int unsigned SQ_W   = 2 * LEVEL_W;
    localparam int unsigned PROD_W = DUTY_W + 16;
    localparam logic [PROD_W-1:0] STEP = PROD_W'(duty_step2(PWM_CYCLE, LEVEL_MAX));

    logic [SQ_W-1:0]   sq;
    logic [PROD_W-1:0] prod;

    always_comb begin
        sq     = SQ_W'(level) * SQ_W'(level);
        prod   = PROD_W'(sq) * STEP;
        duty_c = DUTY_W'(prod);
    end
`else
    localparam int unsigned PROD_W = DUTY_W + 8;
    localparam logic [PROD_W-1:0] STEP = PROD_W'(duty_step(PWM_CYCLE, LEVEL_MAX));

    logic [PROD_W-1:0] prod;

    always_comb begin
        prod   = PROD_W'(level) * STEP;
        duty_c = DUTY_W'(prod);
    end
`endif

endmodule

// File: rtl/breath_duty_gen.sv
// Per-period breathing triangle sequencer (rise/hold/fall/hold) producing the
// PWM on-time for the next period. Mapping selected by BREATH_GAMMA_EN.
module breath_duty_gen
    import breath_pkg::*;
#(
    parameter int unsigned PWM_CYCLE    = 500_000,
    parameter int unsigned DUTY_W       = 19,
    parameter int unsigned LEVEL_MAX    = 10,
    parameter int unsigned STEP_PERIODS = 15,
    parameter int unsigned HOLD_PERIODS = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              period_end,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_vld,
    output logic [7:0]        level,
    output logic [2:0]        phase
);

    localparam int unsigned CNT_MAX = (STEP_PERIODS > HOLD_PERIODS) ? STEP_PERIODS : HOLD_PERIODS;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0]   STEP_LAST = CNT_W'(STEP_PERIODS - 1);
    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'((HOLD_PERIODS == 0) ? 0 : HOLD_PERIODS - 1);
    localparam logic [LEVEL_W-1:0] LVL_TOP   = LEVEL_W'(LEVEL_MAX);
    localparam bit                 HOLD_EN   = (HOLD_PERIODS != 0);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt_per, cnt_nxt;
    logic [LEVEL_W-1:0] level_nxt;
    logic [DUTY_W-1:0]  duty_nxt;

    assign phase = state;

    // Duty follows the next-state level so it lands on the same edge as the step.
    breath_duty_map #(
        .PWM_CYCLE (PWM_CYCLE),
        .DUTY_W    (DUTY_W),
        .LEVEL_MAX (LEVEL_MAX)
    ) u_map (
        .level  (level_nxt),
        .duty_c (duty_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt_per  <= '0;
            level    <= '0;
            duty     <= '0;
            duty_vld <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt_per  <= cnt_nxt;
            level    <= level_nxt;
            duty     <= duty_nxt;
            duty_vld <= (duty_nxt != duty);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_per;
        level_nxt = level;
        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            level_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = RISE;
                    cnt_nxt   = '0;
                end
                RISE: begin
                    if (period_end) begin
                        if (cnt_per == STEP_LAST) begin
                            cnt_nxt   = '0;
                            level_nxt = level + LEVEL_W'(1);
                            if (level_nxt == LVL_TOP) state_nxt = HOLD_EN ? HOLD_HI : FALL;
                        end else begin
                            cnt_nxt = cnt_per + CNT_W'(1);
                        end
                    end
                end
                HOLD_HI: begin
                    if (period_end) begin
                        if (cnt_per == HOLD_LAST) begin
                            cnt_nxt   = '0;
                            state_nxt = FALL;
                        end else begin
                            cnt_nxt = cnt_per + CNT_W'(1);
                        end
                    end
                end
                FALL: begin
                    if (period_end) begin
                        if (cnt_per == STEP_LAST) begin
                            cnt_nxt   = '0;
                            level_nxt = level - LEVEL_W'(1);
                            if (level_nxt == '0) state_nxt = HOLD_EN ? HOLD_LO : RISE;
                        end else begin
                            cnt_nxt = cnt_per + CNT_W'(1);
                        end
                    end
                end
                HOLD_LO: begin
                    if (period_end) begin
                        if (cnt_per == HOLD_LAST) begin
                            cnt_nxt   = '0;
                            state_nxt = RISE;
                        end else begin
                            cnt_nxt = cnt_per + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    level_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_breath_duty_gen.sv
// Bench for breath_duty_gen: one DUT with a one-period hold, one without, sharing stimulus.
module tb_breath_duty_gen;

    localparam int unsigned DW = 19;
    localparam logic [2:0] P_IDLE = 3'd0, P_RISE = 3'd1, P_HH = 3'd2, P_FALL = 3'd3, P_HL = 3'd4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          period_end = 1'b0;
    logic [DW-1:0] duty, duty_nh;
    logic          duty_vld, vld_nh;
    logic [7:0]    level, level_nh;
    logic [2:0]    phase, phase_nh;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] lvl;
        logic [2:0] ph;
        logic       vld;
        logic [7:0] nh_lvl;
        logic [2:0] nh_ph;
        logic       nh_vld;
    } exp_t;

    exp_t sb[$];
    exp_t vec_a[20];
    exp_t vec_b[12];

    always #5 clk = ~clk;

    breath_duty_gen #(
        .PWM_CYCLE(100), .DUTY_W(DW), .LEVEL_MAX(4), .STEP_PERIODS(2), .HOLD_PERIODS(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .period_end(period_end),
        .duty(duty), .duty_vld(duty_vld), .level(level), .phase(phase)
    );

    breath_duty_gen #(
        .PWM_CYCLE(100), .DUTY_W(DW), .LEVEL_MAX(4), .STEP_PERIODS(2), .HOLD_PERIODS(0)
    ) dut_nh (
        .clk(clk), .rst_n(rst_n), .en(en), .period_end(period_end),
        .duty(duty_nh), .duty_vld(vld_nh), .level(level_nh), .phase(phase_nh)
    );

    function automatic exp_t mk(input int l, input logic [2:0] p, input logic v,
                                input int nl, input logic [2:0] np, input logic nv);
        exp_t e;
        e.lvl = 8'(l); e.ph = p; e.vld = v;
        e.nh_lvl = 8'(nl); e.nh_ph = np; e.nh_vld = nv;
        return e;
    endfunction

    // Expected on-time for a level: 100/4 = 25 linear, 100/16 = 6 per level^2 with gamma.
    function automatic logic [DW-1:0] exp_duty(input logic [7:0] l);
        int li;
        li = int'(l);
`ifdef BREATH_GAMMA_EN
        return DW'(li * li * 6);
`else
        return DW'(li * 25);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic cmp_front();
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: empty at compare (t=%0t)", $time);
        end else begin
            e = sb.pop_front();
            check("level", 32'(level), 32'(e.lvl));
            check("duty", 32'(duty), 32'(exp_duty(e.lvl)));
            check("phase", 32'(phase), 32'(e.ph));
            check("duty_vld", 32'(duty_vld), 32'(e.vld));
            check("nh_level", 32'(level_nh), 32'(e.nh_lvl));
            check("nh_duty", 32'(duty_nh), 32'(exp_duty(e.nh_lvl)));
            check("nh_phase", 32'(phase_nh), 32'(e.nh_ph));
            check("nh_duty_vld", 32'(vld_nh), 32'(e.nh_vld));
        end
    endtask

    // Drive one cycle of inputs at a falling edge, then compare after the next rising edge.
    task automatic step(input logic pe, input logic en_v, input logic rst_v, input exp_t e);
        period_end = pe;
        en         = en_v;
        rst_n      = rst_v;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        period_end = 1'b0;
        rst_n      = 1'b1;
        cmp_front();
    endtask

    // Quiet cycles: outputs must hold and no duty_vld may appear.
    task automatic gap(input int n);
        int v = 0;
        int dchg = 0;
        logic [DW-1:0] d0 = duty;
        logic [DW-1:0] d1 = duty_nh;
        repeat (n) begin
            @(negedge clk);
            if (duty_vld || vld_nh) v++;
            if (duty !== d0 || duty_nh !== d1) dchg++;
        end
        check("gap_vld", 32'(v), 32'd0);
        check("gap_duty_stable", 32'(dchg), 32'd0);
    endtask

    initial begin
        vec_a = '{
            mk(0, P_RISE, 0, 0, P_RISE, 0), mk(1, P_RISE, 1, 1, P_RISE, 1),
            mk(1, P_RISE, 0, 1, P_RISE, 0), mk(2, P_RISE, 1, 2, P_RISE, 1),
            mk(2, P_RISE, 0, 2, P_RISE, 0), mk(3, P_RISE, 1, 3, P_RISE, 1),
            mk(3, P_RISE, 0, 3, P_RISE, 0), mk(4, P_HH,   1, 4, P_FALL, 1),
            mk(4, P_FALL, 0, 4, P_FALL, 0), mk(4, P_FALL, 0, 3, P_FALL, 1),
            mk(3, P_FALL, 1, 3, P_FALL, 0), mk(3, P_FALL, 0, 2, P_FALL, 1),
            mk(2, P_FALL, 1, 2, P_FALL, 0), mk(2, P_FALL, 0, 1, P_FALL, 1),
            mk(1, P_FALL, 1, 1, P_FALL, 0), mk(1, P_FALL, 0, 0, P_RISE, 1),
            mk(0, P_HL,   1, 0, P_RISE, 0), mk(0, P_RISE, 0, 1, P_RISE, 1),
            mk(0, P_RISE, 0, 1, P_RISE, 0), mk(1, P_RISE, 1, 2, P_RISE, 1)
        };
        vec_b = '{
            mk(1, P_RISE, 0, 1, P_RISE, 0), mk(2, P_RISE, 1, 2, P_RISE, 1),
            mk(2, P_RISE, 0, 2, P_RISE, 0), mk(3, P_RISE, 1, 3, P_RISE, 1),
            mk(3, P_RISE, 0, 3, P_RISE, 0), mk(4, P_HH,   1, 4, P_FALL, 1),
            mk(4, P_FALL, 0, 4, P_FALL, 0), mk(4, P_FALL, 0, 3, P_FALL, 1),
            mk(3, P_FALL, 1, 3, P_FALL, 0), mk(3, P_FALL, 0, 2, P_FALL, 1),
            mk(2, P_FALL, 1, 2, P_FALL, 0), mk(2, P_FALL, 0, 1, P_FALL, 1)
        };

        // Reset held with en already high.
        en    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_duty", 32'(duty), 32'd0);
        check("rst_phase", 32'(phase), 32'(P_IDLE));
        check("rst_level", 32'(level), 32'd0);
        check("rst_duty_vld", 32'(duty_vld), 32'd0);

        // Release: RISE after one edge, no duty_vld on entry.
        step(1'b0, 1'b1, 1'b1, mk(0, P_RISE, 0, 0, P_RISE, 0));
        gap(99);

        // Full triangle with and without hold, pulses 1..20.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b1, vec_a[i]);
            gap(99);
        end

        // Pulses 21..24 bring the held DUT to level 3.
        step(1'b1, 1'b1, 1'b1, mk(1, P_RISE, 0, 2, P_RISE, 0)); gap(99);
        step(1'b1, 1'b1, 1'b1, mk(2, P_RISE, 1, 3, P_RISE, 1)); gap(99);
        step(1'b1, 1'b1, 1'b1, mk(2, P_RISE, 0, 3, P_RISE, 0)); gap(99);
        step(1'b1, 1'b1, 1'b1, mk(3, P_RISE, 1, 4, P_FALL, 1)); gap(99);

        // en dropped together with period_end: en wins, duty clears with one pulse.
        step(1'b1, 1'b0, 1'b1, mk(0, P_IDLE, 1, 0, P_IDLE, 1));
        gap(5);

        // Re-enable restarts from level 0; first step needs two pulses.
        step(1'b0, 1'b1, 1'b1, mk(0, P_RISE, 0, 0, P_RISE, 0)); gap(99);
        step(1'b1, 1'b1, 1'b1, mk(0, P_RISE, 0, 0, P_RISE, 0)); gap(99);
        step(1'b1, 1'b1, 1'b1, mk(1, P_RISE, 1, 1, P_RISE, 1)); gap(99);

        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b1, vec_b[i]);
            gap(99);
        end

        // Reset in FALL at level 2 coinciding with a stepping pulse: no residual duty_vld.
        step(1'b1, 1'b1, 1'b0, mk(0, P_IDLE, 0, 0, P_IDLE, 0));
        step(1'b0, 1'b1, 1'b1, mk(0, P_RISE, 0, 0, P_RISE, 0));
        gap(3);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
